// File: rtl/pc_gen.sv
// IF-stage program-counter generator: run/halt control, prioritised redirects
// and a circular return-address stack for call/return prediction.
module pc_gen #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned EXC_VEC   = 32'h80,
    parameter int unsigned INC       = 4,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             start_i,
    input  logic                             halt_i,
    input  logic                             stall_i,
    input  logic                             exc_i,
    input  logic                             br_taken_i,
    input  logic [WIDTH-1:0]                 br_target_i,
    input  logic                             call_i,
    input  logic [WIDTH-1:0]                 call_target_i,
    input  logic [WIDTH-1:0]                 link_i,
    input  logic                             ret_i,
    input  logic [WIDTH-1:0]                 ret_target_i,
    output logic [WIDTH-1:0]                 pc_o,
    output logic                             pc_valid_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count_o,
    output logic                             ras_ovf_o,
    output logic                             ras_unf_o
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
    localparam logic [CW-1:0]    FULL   = CW'(RAS_DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] pc_d;
    logic [PW-1:0]    tp_q;
    logic [PW-1:0]    tp_d;
    logic [CW-1:0]    cnt_d;
    logic             push;
    logic             pop;
    logic             clr;
    logic             ovf_d;
    logic             unf_d;
    logic [WIDTH-1:0] mem [RAS_DEPTH];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_o;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            HALT: begin
                if (start_i && !halt_i) state_d = RUN;
            end
            RUN: begin
                // Exception beats both halt and stall; halt drops any redirect.
                if (exc_i) begin
                    pc_d = EXC_PC;
                    clr  = 1'b1;
                end else if (halt_i) begin
                    state_d = HALT;
                end else if (stall_i) begin
                    pc_d = pc_o;
                end else if (br_taken_i) begin
                    pc_d = br_target_i;
                end else if (call_i) begin
                    pc_d  = call_target_i;
                    push  = 1'b1;
                    ovf_d = (ras_count_o == FULL);
                end else if (ret_i) begin
                    if (ras_count_o != '0) begin
                        pc_d = mem[tp_q];
                        pop  = 1'b1;
                    end else begin
                        pc_d  = ret_target_i;
                        unf_d = 1'b1;
                    end
                end else begin
                    pc_d = pc_o + INC_W;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tp_d  = tp_q;
        cnt_d = ras_count_o;
        if (clr) begin
            tp_d  = '0;
            cnt_d = '0;
        end else if (push) begin
            tp_d  = tp_q + PW'(1);
            cnt_d = (ras_count_o == FULL) ? FULL : ras_count_o + CW'(1);
        end else if (pop) begin
            tp_d  = tp_q - PW'(1);
            cnt_d = ras_count_o - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            pc_o        <= RST_PC;
            pc_valid_o  <= 1'b0;
            tp_q        <= '0;
            ras_count_o <= '0;
            ras_ovf_o   <= 1'b0;
            ras_unf_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_o        <= pc_d;
            pc_valid_o  <= (state_d == RUN);
            tp_q        <= tp_d;
            ras_count_o <= cnt_d;
            ras_ovf_o   <= ovf_d;
            ras_unf_o   <= unf_d;
        end
    end

    // Stack contents need no reset; count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) mem[tp_q + PW'(1)] <= link_i;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the IF stage: the next generation of the single-register PC. It holds a run/halt state, selects the next fetch address from exception, branch, call, return and sequential sources by fixed priority, and honours a pipeline stall. It contains a small circular return-address stack (RAS) for call/return redirection. All outputs are registered; every redirect takes effect on the next clock edge.

## Interface
- WIDTH, 32, address width in bits
- RESET_VEC, 0, first fetch address after reset
- EXC_VEC, 32'h80, exception redirect address (truncated to WIDTH)
- INC, 4, sequential increment
- RAS_DEPTH, 4, RAS entries; power of two, ≥2
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  leave IDLE/HALT and begin fetching
- halt_i  in  1  stop fetching; enter HALT
- stall_i  in  1  hold the PC and the RAS this cycle
- exc_i  in  1  redirect to EXC_VEC and clear the RAS
- br_taken_i  in  1  branch redirect
- br_target_i  in  WIDTH  branch target
- call_i  in  1  call: redirect and push the link address
- call_target_i  in  WIDTH  call target
- link_i  in  WIDTH  return address to push
- ret_i  in  1  return: pop the RAS and redirect
- ret_target_i  in  WIDTH  fallback return address, used when the RAS is empty
- pc_o  out  WIDTH  current fetch address
- pc_valid_o  out  1  pc_o is a live fetch address (state RUN)
- ras_count_o  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries
- ras_ovf_o  out  1  one-cycle pulse: a push discarded the oldest entry
- ras_unf_o  out  1  one-cycle pulse: a return found the RAS empty

## Operation
- States:
  - IDLE (after reset), RUN, HALT.
  - IDLE/HALT → RUN on start_i. In HALT, start_i is ignored while halt_i is high.
  - RUN → HALT on halt_i, unless exc_i is high; exc_i takes precedence and the block stays in RUN.
- In IDLE/HALT:
  - pc_o holds its value; the RAS is unchanged.
  - All redirect inputs are ignored, including exc_i.
- In the RUN cycle that follows start_i, pc_o is the held value (RESET_VEC after reset). Advancement begins on the next edge.
- RUN next-PC priority; exactly one source applies:
  1. exc_i → EXC_VEC. RAS is cleared (count 0, pointer 0). Applies even when stall_i is high.
  2. stall_i → hold pc_o and the RAS.
  3. br_taken_i → br_target_i.
  4. call_i → call_target_i, and link_i is pushed.
  5. ret_i → if count > 0, the top entry, which is popped; otherwise ret_target_i with a ras_unf_o pulse.
  6. otherwise pc_o + INC, modulo 2^WIDTH (wraps silently).
- Lower-priority requests in the same cycle are dropped. Example: call_i with br_taken_i does not push.
- RAS:
  - Circular array with top pointer tp.
  - Push writes mem[tp+1], then tp = tp+1 mod DEPTH and count = min(count+1, DEPTH).
  - A push at count == DEPTH overwrites the oldest entry and pulses ras_ovf_o.
  - Pop reads mem[tp], then tp = tp−1 mod DEPTH and count = count−1.
- halt_i together with a redirect in RUN: the state goes to HALT, pc_o holds, and the redirect is dropped.

## Timing
- Reset (asynchronous assert, synchronous to the design on release):
  - pc_o = RESET_VEC, pc_valid_o = 0, state IDLE.
  - ras_count_o = 0, tp = 0, ras_ovf_o = 0, ras_unf_o = 0. RAS contents are don't-care.
- Latency: inputs sampled at edge n set pc_o, pc_valid_o, ras_count_o and the pulses after edge n.
- pc_valid_o changes:
  - rises one edge after start_i is sampled in IDLE/HALT;
  - falls one edge after halt_i is sampled in RUN.
- ras_ovf_o and ras_unf_o are high for exactly one cycle per event.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Test plan
- **Reset and start:** rst_n_i low, then high; start_i held 1 cycle → pc_o = 0 and pc_valid_o = 0 until the edge after start; then 0x0, 0x4, 0x8 on successive cycles.
- **Stall and priority:** stall_i high 3 cycles at pc 0x10 → pc_o stays 0x10. Then br_taken_i (target 0x40) with call_i in the same cycle → pc_o = 0x40 and ras_count_o stays 0.
- **Call/return:** call to 0x100 with link 0x14, then call to 0x200 with link 0x104 → count 2. ret → 0x104; ret → 0x14; count 0.
- **Overflow:** 5 calls with links A–E at RAS_DEPTH=4 → ras_ovf_o pulses on the 5th call. Four rets return E, D, C, B. A 5th ret with ret_target_i = 0x300 → pc 0x300 and ras_unf_o pulses.
- **Exception:** exc_i with stall_i high, RAS count 2 → pc_o = 0x80 and count 0 on the next cycle.
- **Wrap and halt:** WIDTH=8, pc 0xFC → next pc 0x00. Then halt_i with br_taken_i → HALT, pc holds 0x00, pc_valid_o = 0. Assert rst_n_i low asynchronously mid-RUN → pc_o = RESET_VEC before the next edge.
